hi_lo_muldiv_unit: RTL and testbench

- Multiply/divide execution unit holding the architectural HI and LO registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Operands come from the register file read ports. The hi/lo outputs feed the writeback mux that drives the register file write_data for MFHI/MFLO.
- Multiply takes a single cycle. Divide is iterative, and the pipeline control stalls on busy.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/udiv_seq.sv | 50 +++++
 rtl/hi_lo_muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_hi_lo_muldiv_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIV_RUN = 2'b01,
    DIV_FIX = 2'b10
  } md_state_e;

  localparam int DIV_ITERS_DEFAULT = 32;

  // Two's-complement negate when neg is set; used both for |x| and for sign restore.
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/udiv_seq.sv
// Unsigned restoring divider datapath: one quotient bit per step, MSB first.
module udiv_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic         step,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] rem;
  logic [W-1:0] quo;
  logic [W-1:0] dvs;
  logic [W:0]   shifted;
  logic [W:0]   trial;

  // Partial remainder stays below the divisor, so W+1 bits hold the trial sign.
  always_comb begin
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      if (!trial[W]) begin
        rem <= trial[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= shifted[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, iterative signed/unsigned divide.
//   state   | meaning
//   IDLE    | accepts start, MTHI/MTLO
//   DIV_RUN | one restoring step per cycle, DIV_ITERS cycles
//   DIV_FIX | apply signs / divide-by-zero result, write HI/LO
module hi_lo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  md_op_e      op_e;
  md_state_e   state;
  logic [CW-1:0] iter_cnt;

  logic        is_div;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic        div_load;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;

  logic        q_sign;
  logic        r_sign;
  logic        div_zero;
  logic [31:0] orig_a;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    op_e      = md_op_e'(op);
    is_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
    is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
    a_neg     = is_signed & op_a[31];
    b_neg     = is_signed & op_b[31];
    div_load  = (state == IDLE) && start && is_div;
  end

  // Sign/zero-extended 64x64 multiply: the low 64 bits are exact for both signednesses.
  always_comb begin
    ext_a   = {{32{a_neg}}, op_a};
    ext_b   = {{32{b_neg}}, op_b};
    product = ext_a * ext_b;
  end

  udiv_seq #(.W(32)) u_udiv (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (cond_neg(op_a, a_neg)),
    .divisor   (cond_neg(op_b, b_neg)),
    .step      (state == DIV_RUN),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    quo_fix = cond_neg(quo, q_sign);
    rem_fix = cond_neg(rem, r_sign);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      div_zero <= 1'b0;
      orig_a   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_div) begin
              state    <= DIV_RUN;
              busy     <= 1'b1;
              iter_cnt <= '0;
              q_sign   <= a_neg ^ b_neg;
              r_sign   <= a_neg;
              div_zero <= (op_b == 32'd0);
              orig_a   <= op_a;
            end else begin
              hi   <= product[63:32];
              lo   <= product[31:0];
              done <= 1'b1;
            end
          end else begin
            if (write_hi) hi <= write_data;
            if (write_lo) lo <= write_data;
          end
        end
        DIV_RUN: begin
          if (iter_cnt == LAST_ITER) begin
            state    <= DIV_FIX;
            iter_cnt <= '0;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        DIV_FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= div_zero ? orig_a : rem_fix;
          lo    <= div_zero ? 32'hFFFF_FFFF : quo_fix;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Self-checking bench for hi_lo_muldiv_unit: directed corners plus random ops vs. an arithmetic model.
module tb_hi_lo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  hi_lo_muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .op_a       (op_a),
    .op_b       (op_b),
    .write_hi   (write_hi),
    .write_lo   (write_lo),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: plain language-level arithmetic on the architectural rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    int sa, sb;
    rh = '0;
    rl = '0;
    if (o == 2'b00) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      rh = p[63:32];
      rl = p[31:0];
    end else if (o == 2'b01) begin
      p  = {32'd0, a} * {32'd0, b};
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == 32'd0) begin
      rl = 32'hFFFF_FFFF;
      rh = a;
    end else if (o == 2'b11) begin
      rl = a / b;
      rh = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      rl = 32'h8000_0000;
      rh = 32'd0;
    end else begin
      sa = a;
      sb = b;
      rl = sa / sb;
      rh = sa % sb;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude, input bit wr_same, input string tag);
    logic [31:0] eh, el;
    int cnt;
    model(o, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    if (wr_same) begin
      write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op_a = $urandom; op_b = $urandom;
    if (!o[1]) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
    end else begin
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
        chk({tag, "_hold_hi"}, hi, exp_hi);
        chk({tag, "_hold_lo"}, lo, exp_lo);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        if (intrude && cnt == 5) begin
          start = 1'b1; op = 2'b11; op_a = 32'd1000; op_b = 32'd3;
          write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h5555_5555;
        end else begin
          start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
        end
        cnt++;
        @(negedge clk);
      end
      chk({tag, "_busy_cycles"}, cnt, 32'd33);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
    end
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
    chk({tag, "_hi_keep"}, hi, eh);
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d, input string tag);
    @(negedge clk);
    write_hi = wh; write_lo = wl; write_data = d;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0; write_data = $urandom;
    if (wh) exp_hi = d;
    if (wl) exp_lo = d;
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb, rd;
    int sel;
    reset = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_neg3x5");
    chk("mult_neg3x5_abs_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg3x5_abs_lo", lo, 32'hFFFF_FFF1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    chk("multu_max_abs_hi", hi, 32'hFFFF_FFFE);
    chk("multu_max_abs_lo", lo, 32'h0000_0001);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg7_2");
    chk("div_neg7_2_abs_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg7_2_abs_hi", hi, 32'hFFFF_FFFF);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
    chk("divu_100_7_abs_lo", lo, 32'd14);
    chk("divu_100_7_abs_hi", hi, 32'd2);
    do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, "div_5_0");
    do_op(2'b10, 32'hFFFF_FFF6, 32'd0, 1'b0, 1'b0, "div_neg10_0");
    do_op(2'b11, 32'h8765_4321, 32'd0, 1'b0, 1'b0, "divu_x_0");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    chk("div_ovf_abs_lo", lo, 32'h8000_0000);
    chk("div_ovf_abs_hi", hi, 32'd0);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, "div_7_neg2");

    mt_write(1'b1, 1'b1, 32'h1234_5678, "mt_both_a");
    mt_write(1'b0, 1'b1, 32'hCAFE_F00D, "mtlo");
    chk("mt_pair_hi", hi, 32'h1234_5678);
    chk("mt_pair_lo", lo, 32'hCAFE_F00D);
    do_op(2'b10, 32'd100, 32'd7, 1'b1, 1'b0, "div_intrude");
    do_op(2'b00, 32'd9, 32'hFFFF_FFFE, 1'b0, 1'b1, "mult_wr_same");

    // Reset during a divide must abort without writing anything.
    @(negedge clk);
    start = 1'b1; op = 2'b11; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    do_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, "multu_6x7");

    for (int i = 0; i < 24; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) rb = 32'hFFFF_FFFF;
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      if (sel == 3) ra = 32'h8000_0000;
      do_op(ro, ra, rb, 1'b0, 1'b0, "rand_op");
      if ($urandom_range(0, 3) == 0) begin
        rd = $urandom;
        mt_write(1'($urandom_range(0, 1)), 1'b1, rd, "rand_mt");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
